shift_detection: RTL and testbench
==================================

SHIFT_DETECTION -- requirements
Module: shift_detection

Interface
REQ-001 Parameter PAT_LEN, default 4, SHALL set the pattern length in bits (legal range 2..32).
REQ-002 Parameter PATTERN, default 4'b0110, SHALL be the PAT_LEN-bit target sequence; the MSB is the oldest bit received.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port din  input  1  SHALL be the serial data bit, sampled on every rising edge of clk.
REQ-006 Port dout  output  1  SHALL be the registered detect flag, high for the cycle following a pattern match.
REQ-007 Port match_cnt  output  16  SHALL be the saturating detection count; the port exists only when SHIFT_DETECTION_COUNT_EN is defined.

Function
REQ-008 Each rising edge SHALL shift din into an internal PAT_LEN-bit history register at the LSB, discarding the MSB.
REQ-009 A fill counter SHALL count sampled bits since reset, saturating at PAT_LEN.
REQ-010 A match SHALL exist when the history register equals PATTERN and the fill counter equals PAT_LEN, i.e. all history bits are real samples.
REQ-011 dout SHALL be registered from the match term: a pattern whose last bit is sampled at edge E SHALL drive dout=1 from edge E+1 until edge E+2.
REQ-012 Detection SHALL be overlapping: bits of one match SHALL be reusable by the next match, e.g. 0110110 yields two detections.
REQ-013 dout SHALL stay high on consecutive cycles when consecutive edges each produce a match (e.g. PATTERN all-zeros with a constant 0 input).
REQ-014 A mismatch at any position SHALL produce no dout pulse; there is no partial-credit or error output.
REQ-015 The block SHALL have no enable, no handshake and no back-pressure; every clock edge consumes one bit.
REQ-016 Undefined PATTERN bits SHALL NOT exist; elaboration SHALL fail if PAT_LEN is outside 2..32.

Reset
REQ-017 While rst_n=0, the history register SHALL be 0, the fill counter 0, dout 0 and match_cnt 0, asynchronously and independent of clk.
REQ-018 Reset asserted mid-pattern SHALL discard all partial history; the first detection after release SHALL need PAT_LEN fresh samples.
REQ-019 On reset release, sampling SHALL begin at the first rising edge with rst_n=1.

Configuration
REQ-020 With macro SHIFT_DETECTION_COUNT_EN defined, match_cnt SHALL increment by 1 on each edge where dout is loaded with 1, saturating at 16'hFFFF and reset to 0.
REQ-021 Without SHIFT_DETECTION_COUNT_EN, the match_cnt port and counter logic SHALL be absent, and dout behaviour SHALL be identical.

Verification
REQ-022 Reset 10 ns, then din 0,1,1,0 on successive edges -> dout=1 exactly one cycle after the edge sampling the final 0, otherwise 0.
REQ-023 After reset, din 0,1,0,1 -> dout stays 0 throughout.
REQ-024 din 0,1,1,0,0,1,1,0 -> two single-cycle dout pulses; din 0,1,1,0,1,1,0 -> two pulses three cycles apart (overlap).
REQ-025 Immediately after reset, din 1,1,0 only -> no dout pulse (fill-counter guard against reset-zero history).
REQ-026 Assert rst_n low asynchronously between the 3rd and 4th pattern bits, release, then send a single trailing 0 -> dout stays 0, and dout and history clear without a clock edge.
REQ-027 With SHIFT_DETECTION_COUNT_EN defined, three separate 0110 patterns -> match_cnt=3; counter preloaded near 16'hFFFF -> holds at 16'hFFFF.

Source files
------------

// File: rtl/shift_detection.sv
`default_nettype none
// ============================================================================
// Module   : shift_detection
// Purpose  : Serial pattern detector with registered, overlapping detect flag.
//            Define SHIFT_DETECTION_COUNT_EN to add a saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module shift_detection #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic        dout
`ifdef SHIFT_DETECTION_COUNT_EN
  ,
  output logic [15:0] match_cnt
`endif
);

  localparam int                  c_fill_w    = $clog2(PAT_LEN + 1);
  localparam logic [c_fill_w-1:0] c_fill_full = c_fill_w'(PAT_LEN);

  generate
    if ((PAT_LEN < 2) || (PAT_LEN > 32)) begin : g_bad_pat_len
      $error("shift_detection: PAT_LEN must be within 2..32");
    end
  endgenerate

  logic [PAT_LEN-1:0]  r_hist;
  logic [c_fill_w-1:0] r_fill;
  logic                r_dout;
  logic                w_match;

  // The fill guard keeps reset-zero history bits from completing a match.
  assign w_match = (r_hist == PATTERN) && (r_fill == c_fill_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
      r_dout <= 1'b0;
    end else begin
      r_hist <= {r_hist[PAT_LEN-2:0], din};
      if (r_fill != c_fill_full) begin
        r_fill <= r_fill + c_fill_w'(1);
      end
      r_dout <= w_match;
    end
  end

  assign dout = r_dout;

`ifdef SHIFT_DETECTION_COUNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'h0000;
    end else if (w_match && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign match_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_detection.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_detection
// Purpose  : Scoreboard bench for shift_detection (PAT_LEN=4, PATTERN=0110).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_detection;

  localparam int         c_pat_len = 4;
  localparam logic [3:0] c_pattern = 4'b0110;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        din   = 1'b0;
  logic        dout;
`ifdef SHIFT_DETECTION_COUNT_EN
  logic [15:0] match_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [3:0] m_hist;
  int         m_fill;
  int         m_cnt;
  logic       sb_q[$];
  int         pulses;
  int         first_pulse;
  int         last_pulse;

  shift_detection #(
    .PAT_LEN (c_pat_len),
    .PATTERN (c_pattern)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .dout      (dout)
`ifdef SHIFT_DETECTION_COUNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_hist      = '0;
    m_fill      = 0;
    m_cnt       = 0;
    pulses      = 0;
    first_pulse = -1;
    last_pulse  = -1;
    sb_q.delete();
    sb_q.push_back(1'b0);
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_dout"}, 32'(dout), 32'd0);
    check_eq({tag, "_hist"}, 32'(dut.r_hist), 32'd0);
`ifdef SHIFT_DETECTION_COUNT_EN
    check_eq({tag, "_cnt"}, 32'(match_cnt), 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din   = 1'b0;
    #1;
    reset_checks("rst");
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Asserts reset away from any clock edge and checks the clear is immediate.
  task automatic async_reset_mid(input string tag);
    #2 rst_n = 1'b0;
    #1;
    reset_checks(tag);
    model_clear();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic send_bit(input logic b, input string tag);
    logic exp;
    @(negedge clk);
    din    = b;
    m_hist = {m_hist[2:0], b};
    if (m_fill < c_pat_len) m_fill++;
    sb_q.push_back((m_hist == c_pattern) && (m_fill == c_pat_len));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check_eq(tag, 32'(dout), 32'(exp));
      if (exp) m_cnt++;
`ifdef SHIFT_DETECTION_COUNT_EN
      check_eq({tag, "_cnt"}, 32'(match_cnt), 32'(m_cnt));
`endif
    end
    if (dout === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
      last_pulse = cyc;
    end
  endtask

  task automatic send_seq(input logic [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i], tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    do_reset();

    // Single pattern, then zeros to flush the pulse.
    send_seq(32'b0110_000, 7, "single");
    check_eq("single_pulses", 32'(pulses), 32'd1);

    // Non-matching pattern.
    do_reset();
    send_seq(32'b0101_000, 7, "nomatch");
    check_eq("nomatch_pulses", 32'(pulses), 32'd0);

    // Back-to-back patterns without overlap.
    do_reset();
    send_seq(32'b01100110_00, 10, "double");
    check_eq("double_pulses", 32'(pulses), 32'd2);
    check_eq("double_gap", 32'(last_pulse - first_pulse), 32'd4);

    // Overlapping patterns share the middle 0.
    do_reset();
    send_seq(32'b0110110_00, 9, "overlap");
    check_eq("overlap_pulses", 32'(pulses), 32'd2);
    check_eq("overlap_gap", 32'(last_pulse - first_pulse), 32'd3);

    // Reset-zero history must not complete the pattern.
    do_reset();
    send_seq(32'b110_000, 6, "fill_guard");
    check_eq("fill_guard_pulses", 32'(pulses), 32'd0);

    // Reset between 3rd and 4th bits discards partial history.
    do_reset();
    send_seq(32'b011, 3, "midrst_pre");
    async_reset_mid("midrst");
    send_seq(32'b0_000, 4, "midrst_post");
    check_eq("midrst_pulses", 32'(pulses), 32'd0);

    // Reset while dout is high clears it without a clock edge.
    do_reset();
    send_seq(32'b01100, 5, "hot");
    check_eq("hot_dout_high", 32'(dout), 32'd1);
    async_reset_mid("hotrst");
    send_seq(32'b000, 3, "hot_post");

    // Random stream with the scoreboard tracking every cycle.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ((i % 17) == 0) send_seq(32'b0110, 4, "rand_inj");
      else               send_bit(1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
